// File: rtl/sad_row_acc.sv
// sad_row_acc -- row SAD accumulator for block-matching motion estimation.
// Stage 1 registers the 16 |ref - srh| terms of an accepted row. Stage 2 forms
// the four candidate row sums and accumulates them, with saturation, over ROWS
// rows. Stage 3 picks the minimum at block end; ties go to the lowest index.
// Optional build macro: SAD_ALL_OUT_EN adds sad0_o..sad3_o (final block totals).
module sad_row_acc #(
  parameter int ROWS  = 4,
  parameter int SAD_W = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic                    clr,
  input  logic [7:0]              ref0,
  input  logic [7:0]              ref1,
  input  logic [7:0]              ref2,
  input  logic [7:0]              ref3,
  input  logic [7:0]              srh0,
  input  logic [7:0]              srh1,
  input  logic [7:0]              srh2,
  input  logic [7:0]              srh3,
  input  logic [7:0]              srh4,
  input  logic [7:0]              srh5,
  input  logic [7:0]              srh6,
  output logic                    done_o,
  output logic [SAD_W-1:0]        min_sad_o,
  output logic [1:0]              min_idx_o,
  output logic [$clog2(ROWS)-1:0] row_cnt_o
`ifdef SAD_ALL_OUT_EN
  ,
  output logic [SAD_W-1:0]        sad0_o,
  output logic [SAD_W-1:0]        sad1_o,
  output logic [SAD_W-1:0]        sad2_o,
  output logic [SAD_W-1:0]        sad3_o
`endif
);

  localparam int CW = $clog2(ROWS);
  localparam int AW = SAD_W + 1;
  localparam logic [SAD_W-1:0] SAT_MAX  = '1;
  localparam logic [CW-1:0]    LAST_ROW = CW'(ROWS - 1);

  logic [7:0]       ref_px  [4];
  logic [7:0]       srh_px  [7];
  logic [7:0]       ad_q    [4][4];  // [candidate k][pixel i]
  logic             v1_q;
  logic [9:0]       row_sad [4];
  logic [AW-1:0]    acc_sum [4];
  logic [SAD_W-1:0] acc_nxt [4];
  logic [SAD_W-1:0] acc_q   [4];
  logic [CW-1:0]    row_cnt_q;
  logic             v2_last_q;
  logic [SAD_W-1:0] best_sad;
  logic [1:0]       best_idx;

  assign ref_px[0] = ref0;
  assign ref_px[1] = ref1;
  assign ref_px[2] = ref2;
  assign ref_px[3] = ref3;
  assign srh_px[0] = srh0;
  assign srh_px[1] = srh1;
  assign srh_px[2] = srh2;
  assign srh_px[3] = srh3;
  assign srh_px[4] = srh4;
  assign srh_px[5] = srh5;
  assign srh_px[6] = srh6;

  assign row_cnt_o = row_cnt_q;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Stage 1: register the absolute differences of an accepted row (clr drops it)
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      v1_q <= 1'b0;
      for (int unsigned k = 0; k < 4; k++)
        for (int unsigned i = 0; i < 4; i++)
          ad_q[k][i] <= '0;
    end else begin
      v1_q <= en && !clr;
      if (en && !clr) begin
        for (int unsigned k = 0; k < 4; k++)
          for (int unsigned i = 0; i < 4; i++)
            ad_q[k][i] <= absdiff(ref_px[i], srh_px[i + k]);
      end
    end
  end

  // Stage 2 datapath: row sums, then load (first row) or saturating add
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      row_sad[k] = '0;
      for (int unsigned i = 0; i < 4; i++)
        row_sad[k] = row_sad[k] + {2'b00, ad_q[k][i]};
      acc_sum[k] = {1'b0, acc_q[k]} + AW'(row_sad[k]);
      if (row_cnt_q == '0)
        acc_nxt[k] = SAD_W'(row_sad[k]);
      else if (acc_sum[k][SAD_W])
        acc_nxt[k] = SAT_MAX;
      else
        acc_nxt[k] = acc_sum[k][SAD_W-1:0];
    end
  end

  // Stage 2 state: accumulators, row counter and last-row flag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_cnt_q <= '0;
      v2_last_q <= 1'b0;
      for (int unsigned k = 0; k < 4; k++)
        acc_q[k] <= '0;
    end else if (clr) begin
      row_cnt_q <= '0;
      v2_last_q <= 1'b0;
      for (int unsigned k = 0; k < 4; k++)
        acc_q[k] <= '0;
    end else begin
      v2_last_q <= v1_q && (row_cnt_q == LAST_ROW);
      if (v1_q) begin
        row_cnt_q <= (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + 1'b1;
        for (int unsigned k = 0; k < 4; k++)
          acc_q[k] <= acc_nxt[k];
      end
    end
  end

  // Stage 3 compare: strict less-than scan so ties keep the lowest k
  always_comb begin
    best_sad = acc_q[0];
    best_idx = '0;
    for (int unsigned k = 1; k < 4; k++) begin
      if (acc_q[k] < best_sad) begin
        best_sad = acc_q[k];
        best_idx = 2'(k);
      end
    end
  end

  // Stage 3 result: capture minimum and pulse done_o; clr does not cancel it
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_o    <= 1'b0;
      min_sad_o <= '0;
      min_idx_o <= '0;
    end else begin
      done_o <= v2_last_q;
      if (v2_last_q) begin
        min_sad_o <= best_sad;
        min_idx_o <= best_idx;
      end
    end
  end

`ifdef SAD_ALL_OUT_EN
  // Final block totals, captured together with the minimum
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sad0_o <= '0;
      sad1_o <= '0;
      sad2_o <= '0;
      sad3_o <= '0;
    end else if (v2_last_q) begin
      sad0_o <= acc_q[0];
      sad1_o <= acc_q[1];
      sad2_o <= acc_q[2];
      sad3_o <= acc_q[3];
    end
  end
`endif

endmodule

// File: tb/tb_sad_row_acc.sv
// Testbench for sad_row_acc: a row-level reference model predicts each block
// result (cycle, minimum, index) for a 16-bit and a 10-bit (saturating) DUT.
`timescale 1ns/1ps
module tb_sad_row_acc;

  localparam int ROWS = 4;
  localparam int W    = 16;
  localparam int WS   = 10;

  logic            clk = 1'b0;
  logic            nrst, en, clr;
  logic [7:0]      r [4];
  logic [7:0]      s [7];
  logic            done, done_s;
  logic [W-1:0]    msad;
  logic [WS-1:0]   msad_s;
  logic [1:0]      midx, midx_s;
  logic [1:0]      rcnt, rcnt_s;
`ifdef SAD_ALL_OUT_EN
  logic [W-1:0]    sad   [4];
  logic [WS-1:0]   sad_s [4];
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sad_row_acc #(.ROWS(ROWS), .SAD_W(W)) dut (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr),
    .ref0(r[0]), .ref1(r[1]), .ref2(r[2]), .ref3(r[3]),
    .srh0(s[0]), .srh1(s[1]), .srh2(s[2]), .srh3(s[3]),
    .srh4(s[4]), .srh5(s[5]), .srh6(s[6]),
    .done_o(done), .min_sad_o(msad), .min_idx_o(midx), .row_cnt_o(rcnt)
`ifdef SAD_ALL_OUT_EN
    , .sad0_o(sad[0]), .sad1_o(sad[1]), .sad2_o(sad[2]), .sad3_o(sad[3])
`endif
  );

  sad_row_acc #(.ROWS(ROWS), .SAD_W(WS)) dut_sat (
    .clk(clk), .nrst(nrst), .en(en), .clr(clr),
    .ref0(r[0]), .ref1(r[1]), .ref2(r[2]), .ref3(r[3]),
    .srh0(s[0]), .srh1(s[1]), .srh2(s[2]), .srh3(s[3]),
    .srh4(s[4]), .srh5(s[5]), .srh6(s[6]),
    .done_o(done_s), .min_sad_o(msad_s), .min_idx_o(midx_s), .row_cnt_o(rcnt_s)
`ifdef SAD_ALL_OUT_EN
    , .sad0_o(sad_s[0]), .sad1_o(sad_s[1]), .sad2_o(sad_s[2]), .sad3_o(sad_s[3])
`endif
  );

  // ---------------- reference model ----------------
  typedef struct { int t; int d [4]; } row_t;
  typedef struct {
    int t; logic [1:0] dn; int mn; int ix; int smn; int six;
    logic [4*W-1:0] sads; logic [4*WS-1:0] ssads;
  } res_t;

  int   cyc = 0;
  row_t pend [$];
  res_t exp_q [$];
  res_t obs_q [$];
  int   tot [4];
  int   nsum = 0;
  row_t mrow;
  res_t b, o;
  int   tw [4];
  int   ts [4];

  function automatic int row_sad(input int k);
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      int a = int'(r[i]);
      int c = int'(s[i + k]);
      sum += (a > c) ? a - c : c - a;
    end
    return sum;
  endfunction

  // A row accepted in cycle C joins its block total at the end of cycle C+1;
  // a completed block is reported in cycle C+3. clr discards the partial block.
  initial forever begin
    @(posedge clk or negedge nrst);
    if (!nrst) begin
      pend.delete(); exp_q.delete(); nsum = 0;
      for (int k = 0; k < 4; k++) tot[k] = 0;
    end else begin
      if (clr) begin
        pend.delete(); nsum = 0;
        for (int k = 0; k < 4; k++) tot[k] = 0;
      end else if (pend.size() > 0) begin
        mrow = pend.pop_front();
        for (int k = 0; k < 4; k++) tot[k] += mrow.d[k];
        nsum++;
        if (nsum == ROWS) begin
          for (int k = 0; k < 4; k++) begin
            tw[k] = (tot[k] > (1 << W) - 1)  ? (1 << W) - 1  : tot[k];
            ts[k] = (tot[k] > (1 << WS) - 1) ? (1 << WS) - 1 : tot[k];
          end
          b.t = cyc + 2; b.dn = 2'b11;
          b.mn = tw[0]; b.ix = 0; b.smn = ts[0]; b.six = 0;
          for (int k = 1; k < 4; k++) begin
            if (tw[k] < b.mn)  begin b.mn = tw[k];  b.ix = k;  end
            if (ts[k] < b.smn) begin b.smn = ts[k]; b.six = k; end
          end
          b.sads = '0; b.ssads = '0;
`ifdef SAD_ALL_OUT_EN
          for (int k = 0; k < 4; k++) begin
            b.sads[k*W +: W]    = W'(tw[k]);
            b.ssads[k*WS +: WS] = WS'(ts[k]);
          end
`endif
          exp_q.push_back(b);
          nsum = 0;
          for (int k = 0; k < 4; k++) tot[k] = 0;
        end
      end
      if (en && !clr) begin
        mrow.t = cyc;
        for (int k = 0; k < 4; k++) mrow.d[k] = row_sad(k);
        pend.push_back(mrow);
      end
      cyc++;
    end
  end

  // Records every done pulse observed on either DUT
  initial forever begin
    @(posedge clk);
    #1;
    if (done || done_s) begin
      o.t = cyc; o.dn = {done, done_s};
      o.mn = int'(msad); o.ix = int'(midx); o.smn = int'(msad_s); o.six = int'(midx_s);
      o.sads = '0; o.ssads = '0;
`ifdef SAD_ALL_OUT_EN
      for (int k = 0; k < 4; k++) begin
        o.sads[k*W +: W]    = sad[k];
        o.ssads[k*WS +: WS] = sad_s[k];
      end
`endif
      obs_q.push_back(o);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_px(input int a0, input int a1, input int a2, input int a3,
                         input int b0, input int b1, input int b2, input int b3,
                         input int b4, input int b5, input int b6);
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    s[0] = 8'(b0); s[1] = 8'(b1); s[2] = 8'(b2); s[3] = 8'(b3);
    s[4] = 8'(b4); s[5] = 8'(b5); s[6] = 8'(b6);
  endtask

  task automatic step(input bit e, input bit c);
    en = e; clr = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    nrst = 1'b0; en = 1'b0; clr = 1'b0;
    load_px(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    n_tests++;
    if ({done, done_s} !== 2'b00 || msad !== '0 || midx !== '0 || rcnt !== '0 ||
        msad_s !== '0 || midx_s !== '0 || rcnt_s !== '0) begin
      n_fail++;
      $display("FAIL reset_init: got done=%b min=%0d idx=%0d cnt=%0d satmin=%0d, want all 0",
               {done, done_s}, msad, midx, rcnt, msad_s);
    end
    nrst = 1'b1;
    @(negedge clk);
    exp_q.delete(); obs_q.delete();
    load_px(0, 0, 0, 0, 200, 210, 220, 230, 240, 250, 255);
    repeat (4) step(1'b1, 1'b0);
    idle(5);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL reset_preblock: got %0d done pulses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_tests++;
      if (obs_q[j].t != exp_q[j].t || obs_q[j].dn != exp_q[j].dn || obs_q[j].mn != exp_q[j].mn ||
          obs_q[j].ix != exp_q[j].ix || obs_q[j].smn != exp_q[j].smn || obs_q[j].six != exp_q[j].six ||
          obs_q[j].sads != exp_q[j].sads || obs_q[j].ssads != exp_q[j].ssads) begin
        n_fail++;
        $display("FAIL reset_preblock blk%0d: got t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d, want t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d",
                 j, obs_q[j].t, obs_q[j].dn, obs_q[j].mn, obs_q[j].ix, obs_q[j].smn, obs_q[j].six,
                 exp_q[j].t, exp_q[j].dn, exp_q[j].mn, exp_q[j].ix, exp_q[j].smn, exp_q[j].six);
      end
    end
    // Mid-block asynchronous reset with en still high
    step(1'b1, 1'b0);
    en = 1'b1;
    #3 nrst = 1'b0;
    #1;
    n_tests++;
    if ({done, done_s} !== 2'b00 || msad !== '0 || midx !== '0 || rcnt !== '0 ||
        msad_s !== '0 || midx_s !== '0 || rcnt_s !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got done=%b min=%0d idx=%0d cnt=%0d satmin=%0d, want all 0",
               {done, done_s}, msad, midx, rcnt, msad_s);
    end
`ifdef SAD_ALL_OUT_EN
    n_tests++;
    if (sad[0] !== '0 || sad[1] !== '0 || sad[2] !== '0 || sad[3] !== '0) begin
      n_fail++;
      $display("FAIL reset_sads: got %0d %0d %0d %0d, want 0 0 0 0", sad[0], sad[1], sad[2], sad[3]);
    end
`endif
    @(negedge clk);
    en = 1'b0;
    nrst = 1'b1;
    exp_q.delete(); obs_q.delete();
    idle(8);
    n_tests++;
    if (obs_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_quiet: got %0d done pulses after release, want 0", obs_q.size());
    end
  endtask

  task automatic test_gap_free;
    int t_last;
    exp_q.delete(); obs_q.delete();
    load_px(10, 10, 10, 10, 10, 10, 10, 10, 20, 20, 20);
    repeat (3) step(1'b1, 1'b0);
    t_last = cyc;
    step(1'b1, 1'b0);
    idle(6);
    n_tests++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL gap_free_count: got %0d done pulses, want %0d (model %0d)", obs_q.size(), 1, exp_q.size());
    end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_tests++;
      if (obs_q[j].t != exp_q[j].t || obs_q[j].dn != exp_q[j].dn || obs_q[j].mn != exp_q[j].mn ||
          obs_q[j].ix != exp_q[j].ix || obs_q[j].smn != exp_q[j].smn || obs_q[j].six != exp_q[j].six ||
          obs_q[j].sads != exp_q[j].sads || obs_q[j].ssads != exp_q[j].ssads) begin
        n_fail++;
        $display("FAIL gap_free blk%0d: got t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d sads=%h, want t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d sads=%h",
                 j, obs_q[j].t, obs_q[j].dn, obs_q[j].mn, obs_q[j].ix, obs_q[j].smn, obs_q[j].six, obs_q[j].sads,
                 exp_q[j].t, exp_q[j].dn, exp_q[j].mn, exp_q[j].ix, exp_q[j].smn, exp_q[j].six, exp_q[j].sads);
      end
    end
    if (obs_q.size() > 0) begin
      n_tests++;
      if (obs_q[0].t != t_last + 3 || obs_q[0].mn != 0 || obs_q[0].ix != 0) begin
        n_fail++;
        $display("FAIL gap_free_direct: got t=%0d min=%0d idx=%0d, want t=%0d min=0 idx=0",
                 obs_q[0].t, obs_q[0].mn, obs_q[0].ix, t_last + 3);
      end
    end
  endtask

  task automatic test_gaps;
    int t_last;
    exp_q.delete(); obs_q.delete();
    load_px(10, 10, 10, 10, 0, 0, 0, 10, 10, 10, 10);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
    t_last = cyc;
    step(1'b1, 1'b0);
    idle(6);
    n_tests++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL gaps_count: got %0d done pulses, want 1 (model %0d)", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_tests++;
      if (obs_q[j].t != exp_q[j].t || obs_q[j].dn != exp_q[j].dn || obs_q[j].mn != exp_q[j].mn ||
          obs_q[j].ix != exp_q[j].ix || obs_q[j].smn != exp_q[j].smn || obs_q[j].six != exp_q[j].six ||
          obs_q[j].sads != exp_q[j].sads || obs_q[j].ssads != exp_q[j].ssads) begin
        n_fail++;
        $display("FAIL gaps blk%0d: got t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d sads=%h, want t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d sads=%h",
                 j, obs_q[j].t, obs_q[j].dn, obs_q[j].mn, obs_q[j].ix, obs_q[j].smn, obs_q[j].six, obs_q[j].sads,
                 exp_q[j].t, exp_q[j].dn, exp_q[j].mn, exp_q[j].ix, exp_q[j].smn, exp_q[j].six, exp_q[j].sads);
      end
    end
    if (obs_q.size() > 0) begin
      n_tests++;
      if (obs_q[0].t != t_last + 3 || obs_q[0].mn != 0 || obs_q[0].ix != 3) begin
        n_fail++;
        $display("FAIL gaps_direct: got t=%0d min=%0d idx=%0d, want t=%0d min=0 idx=3",
                 obs_q[0].t, obs_q[0].mn, obs_q[0].ix, t_last + 3);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_q.delete(); obs_q.delete();
    load_px(10, 10, 10, 10, 10, 10, 10, 10, 20, 20, 20);
    repeat (4) step(1'b1, 1'b0);
    load_px(50, 50, 50, 50, 50, 50, 50, 50, 50, 50, 50);
    repeat (4) step(1'b1, 1'b0);
    idle(6);
    n_tests++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses, want 2 (model %0d)", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_tests++;
      if (obs_q[j].t != exp_q[j].t || obs_q[j].dn != exp_q[j].dn || obs_q[j].mn != exp_q[j].mn ||
          obs_q[j].ix != exp_q[j].ix || obs_q[j].smn != exp_q[j].smn || obs_q[j].six != exp_q[j].six ||
          obs_q[j].sads != exp_q[j].sads || obs_q[j].ssads != exp_q[j].ssads) begin
        n_fail++;
        $display("FAIL b2b blk%0d: got t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d, want t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d",
                 j, obs_q[j].t, obs_q[j].dn, obs_q[j].mn, obs_q[j].ix, obs_q[j].smn, obs_q[j].six,
                 exp_q[j].t, exp_q[j].dn, exp_q[j].mn, exp_q[j].ix, exp_q[j].smn, exp_q[j].six);
      end
    end
    if (obs_q.size() > 1) begin
      n_tests++;
      if (obs_q[1].t - obs_q[0].t != 4 || obs_q[1].mn != 0 || obs_q[1].ix != 0) begin
        n_fail++;
        $display("FAIL b2b_direct: got spacing=%0d min=%0d idx=%0d, want spacing=4 min=0 idx=0",
                 obs_q[1].t - obs_q[0].t, obs_q[1].mn, obs_q[1].ix);
      end
    end
  endtask

  task automatic test_saturation;
    exp_q.delete(); obs_q.delete();
    load_px(0, 0, 0, 0, 255, 255, 255, 255, 255, 255, 255);
    repeat (4) step(1'b1, 1'b0);
    idle(6);
    n_tests++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL sat_count: got %0d done pulses, want 1 (model %0d)", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_tests++;
      if (obs_q[j].t != exp_q[j].t || obs_q[j].dn != exp_q[j].dn || obs_q[j].mn != exp_q[j].mn ||
          obs_q[j].ix != exp_q[j].ix || obs_q[j].smn != exp_q[j].smn || obs_q[j].six != exp_q[j].six ||
          obs_q[j].sads != exp_q[j].sads || obs_q[j].ssads != exp_q[j].ssads) begin
        n_fail++;
        $display("FAIL sat blk%0d: got t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d ssads=%h, want t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d ssads=%h",
                 j, obs_q[j].t, obs_q[j].dn, obs_q[j].mn, obs_q[j].ix, obs_q[j].smn, obs_q[j].six, obs_q[j].ssads,
                 exp_q[j].t, exp_q[j].dn, exp_q[j].mn, exp_q[j].ix, exp_q[j].smn, exp_q[j].six, exp_q[j].ssads);
      end
    end
    if (obs_q.size() > 0) begin
      n_tests++;
      if (obs_q[0].smn != 1023 || obs_q[0].six != 0 || obs_q[0].mn != 4080) begin
        n_fail++;
        $display("FAIL sat_direct: got satmin=%0d satidx=%0d min16=%0d, want satmin=1023 satidx=0 min16=4080",
                 obs_q[0].smn, obs_q[0].six, obs_q[0].mn);
      end
    end
  endtask

  task automatic test_abort;
    logic [1:0] cnt_before;
    exp_q.delete(); obs_q.delete();
    load_px(10, 10, 10, 10, 0, 0, 0, 10, 10, 10, 10);
    repeat (2) step(1'b1, 1'b0);
    cnt_before = rcnt;
    step(1'b1, 1'b1);
    n_tests++;
    if (rcnt !== 2'd0 || rcnt_s !== 2'd0 || cnt_before !== 2'd1) begin
      n_fail++;
      $display("FAIL abort_cnt: got cnt=%0d/%0d (before clr %0d), want 0/0 (before clr 1)",
               rcnt, rcnt_s, cnt_before);
    end
    load_px(10, 10, 10, 10, 10, 10, 10, 10, 20, 20, 20);
    repeat (4) step(1'b1, 1'b0);
    idle(6);
    n_tests++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      n_fail++;
      $display("FAIL abort_count: got %0d done pulses, want 1 (model %0d)", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_tests++;
      if (obs_q[j].t != exp_q[j].t || obs_q[j].dn != exp_q[j].dn || obs_q[j].mn != exp_q[j].mn ||
          obs_q[j].ix != exp_q[j].ix || obs_q[j].smn != exp_q[j].smn || obs_q[j].six != exp_q[j].six ||
          obs_q[j].sads != exp_q[j].sads || obs_q[j].ssads != exp_q[j].ssads) begin
        n_fail++;
        $display("FAIL abort blk%0d: got t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d sads=%h, want t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d sads=%h",
                 j, obs_q[j].t, obs_q[j].dn, obs_q[j].mn, obs_q[j].ix, obs_q[j].smn, obs_q[j].six, obs_q[j].sads,
                 exp_q[j].t, exp_q[j].dn, exp_q[j].mn, exp_q[j].ix, exp_q[j].smn, exp_q[j].six, exp_q[j].sads);
      end
    end
    if (obs_q.size() > 0) begin
      n_tests++;
      if (obs_q[0].mn != 0 || obs_q[0].ix != 0) begin
        n_fail++;
        $display("FAIL abort_direct: got min=%0d idx=%0d, want min=0 idx=0", obs_q[0].mn, obs_q[0].ix);
      end
    end
  endtask

  task automatic test_random;
    int mx;
    exp_q.delete(); obs_q.delete();
    mx = 255;
    for (int c = 0; c < 400; c++) begin
      if (c % 40 == 0) mx = ($urandom_range(0, 1) == 1) ? 3 : 255;
      for (int i = 0; i < 4; i++) r[i] = 8'($urandom_range(0, mx));
      for (int i = 0; i < 7; i++) s[i] = 8'($urandom_range(0, mx));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
      n_tests++;
      if (rcnt !== 2'(nsum) || rcnt_s !== 2'(nsum)) begin
        n_fail++;
        $display("FAIL rand_cnt cyc%0d: got cnt=%0d/%0d, want %0d", cyc, rcnt, rcnt_s, nsum);
      end
    end
    idle(6);
    n_tests++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d done pulses, want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[j]) if (j < obs_q.size()) begin
      n_tests++;
      if (obs_q[j].t != exp_q[j].t || obs_q[j].dn != exp_q[j].dn || obs_q[j].mn != exp_q[j].mn ||
          obs_q[j].ix != exp_q[j].ix || obs_q[j].smn != exp_q[j].smn || obs_q[j].six != exp_q[j].six ||
          obs_q[j].sads != exp_q[j].sads || obs_q[j].ssads != exp_q[j].ssads) begin
        n_fail++;
        $display("FAIL rand blk%0d: got t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d, want t=%0d dn=%b min=%0d idx=%0d satmin=%0d satidx=%0d",
                 j, obs_q[j].t, obs_q[j].dn, obs_q[j].mn, obs_q[j].ix, obs_q[j].smn, obs_q[j].six,
                 exp_q[j].t, exp_q[j].dn, exp_q[j].mn, exp_q[j].ix, exp_q[j].smn, exp_q[j].six);
      end
    end
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0; clr = 1'b0;
    test_reset;
    test_gap_free;
    test_gaps;
    test_back_to_back;
    test_saturation;
    test_abort;
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_row_acc.md
Name: sad_row_acc

Overview:
Downstream consumer of the row-hold register stage in the block-matching motion-estimation path. Each enabled cycle it takes one row: 4 reference pixels and a 7-pixel search strip. It computes the row SAD for the 4 horizontal candidate offsets and accumulates these over ROWS rows. At block end it reports the minimum SAD and the winning candidate index.

Parameters:
ROWS, 4, rows per block (valid range 2..64)
SAD_W, 16, accumulator/output width in bits (valid range 10..24); accumulation saturates at 2^SAD_W-1

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
en  input  1  row valid; ref*/srh* sampled when high
clr  input  1  synchronous abort; discards partial block
ref0..ref3  input  8 each  reference pixels, unsigned
srh0..srh6  input  8 each  search strip pixels, unsigned
done_o  output  1  one-cycle pulse; min outputs updated
min_sad_o  output  SAD_W  minimum accumulated SAD of last block
min_idx_o  output  2  candidate offset k (0..3) of minimum
row_cnt_o  output  clog2(ROWS)  rows accumulated in current block

Behaviour:
- Clock and reset: single clock domain clk; reset is asynchronous, active-low (nrst). Reset clears all state: done_o=0, min_sad_o=0, min_idx_o=0, row_cnt_o=0, pipeline valids=0, accumulators=0.
- Candidate k (0..3): row_sad_k = sum over i=0..3 of |ref_i - srh_(i+k)|. Row_sad_k is unsigned, max 1020, 10 bits.
- Stage 1 (cycle T+1 after an en cycle T): 16 absolute differences registered, with v1=en.
- Stage 2 (T+2): the 4 row sums are formed and combined into acc0..acc3.
  - If row_cnt==0, acc_k loads row_sad_k.
  - Otherwise acc_k adds row_sad_k, saturating at 2^SAD_W-1.
  - row_cnt increments. On the ROWS-th row it wraps to 0 and asserts v2_last.
- Stage 3 (T+3 for the last row): compare the final acc values (the stage-2 results including the last row).
  - Strict less-than, scanning k=0..3; ties resolve to the lowest k.
  - Register min_sad_o and min_idx_o, and pulse done_o for exactly 1 cycle.
  - min_* hold until the next done_o.
- Latency: last row's en at cycle T gives done_o high at T+3.
- en may drop between rows. Idle cycles do not advance row_cnt or alter the accumulators, and the result is identical to gap-free input.
- Back-to-back blocks are fully pipelined. Row 1 of block N+1 may arrive the cycle after the last row of block N; the load-on-row_cnt==0 rule keeps the blocks separate. done_o pulses can occur every ROWS cycles.
- clr=1:
  - Clears row_cnt, v1, v2 and acc* at the next edge. Rows in flight are discarded, and done_o is not asserted for the aborted block.
  - min_* retain their previous values.
  - If clr and en coincide, clr wins and the row is dropped.
  - A done_o already in stage 3 when clr arrives still fires.
- Reset mid-block: all state is cleared immediately, regardless of clk.

Optional Feature:
Macro SAD_ALL_OUT_EN.
- Defined: adds output ports sad0_o..sad3_o (SAD_W each). These are registered alongside min_sad_o, carry the four final block totals, update on done_o, and reset to 0.
- Undefined: those ports do not exist, the final-total registers are removed, and all other behaviour is identical.

Test Plan:
1. Reset: assert nrst=0 mid-stream with en=1 -> all outputs 0 immediately; after release with no en, done_o stays 0.
2. ROWS=4, ref=10 all, srh={10,10,10,10,20,20,20}, en high 4 consecutive cycles -> done_o at last-row cycle+3; min_sad_o=0, min_idx_o=0; with SAD_ALL_OUT_EN, sad0..3=0,40,80,120.
3. Best at offset 3 with gaps: ref=10, srh={0,0,0,10,10,10,10}, 4 rows with one idle cycle between each -> single done_o 3 cycles after row 4; min_sad_o=0, min_idx_o=3 (others 120,80,40).
4. Back-to-back + tie: 8 consecutive rows, block A as scenario 2, block B all pixels 50 -> two done_o pulses 4 cycles apart; second gives min_sad_o=0, min_idx_o=0 (tie to lowest).
5. Saturation: SAD_W=10, ROWS=4, ref=0, srh=255 all -> each row 1020, accumulation saturates; min_sad_o=1023, min_idx_o=0.
6. Abort: 2 rows of scenario 3, clr=1 coincident with a 3rd en, then 4 rows of scenario 2 -> exactly one done_o, min_idx_o=0, min_sad_o=0; row_cnt_o=0 the cycle after clr.
